// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types and constants for the i8080 instruction-trace recorder.
// Record layout, LSB first: hl, f, a, pc, step.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        READ  = 2'd3
    } state_e;

    localparam int STEP_W_DEF  = 16;
    localparam int REC_FIXED_W = 48;
    localparam int REC_W       = STEP_W_DEF + REC_FIXED_W;

    localparam int HL_LSB   = 0;
    localparam int F_LSB    = 16;
    localparam int A_LSB    = 24;
    localparam int PC_LSB   = 32;
    localparam int STEP_LSB = 48;

    function automatic logic pc_match(input logic [15:0] pc_v,
                                      input logic [15:0] ref_v,
                                      input logic [15:0] mask_v);
        return ((pc_v ^ ref_v) & mask_v) == 16'h0000;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Valid/ready replay stream carrying one trace record per beat.
interface cpu_trace_buffer_if #(
    parameter int STEP_W = 16
);
    import trace_pkg::*;

    logic                          out_valid;
    logic                          out_ready;
    logic [STEP_W+REC_FIXED_W-1:0] out_data;
    logic                          out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rdata_r;

    // Storage array; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register holds its word until the next read enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular instruction-trace capture buffer with PC trigger and oldest-first replay.
// Optional PC window filter enabled by defining TRACE_FILTER_EN.
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int STEP_W = 16,
    parameter int POST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m1_strobe,
    input  logic [15:0]       pc,
    input  logic [7:0]        a,
    input  logic [7:0]        f,
    input  logic [15:0]       hl,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              trig_en,
    input  logic [15:0]       trig_pc,
    input  logic [15:0]       trig_mask,
    input  logic [POST_W-1:0] post_count,
    input  logic [15:0]       filt_lo,
    input  logic [15:0]       filt_hi,
    cpu_trace_buffer_if.master out_if,
    output logic              busy,
    output logic              triggered,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RW    = STEP_W + REC_FIXED_W;

    state_e            state_r, next_state_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, remaining_r;
    logic [STEP_W-1:0] step_r;
    logic [POST_W-1:0] post_left_r;
    logic              triggered_r, overflow_r, busy_r;
    logic              out_valid_r, out_last_r;

    logic              pass_s, active_s, clear_s, cap_s, step_inc_s, trig_s;
    logic              post_done_s, rd_start_s, hs_s, last_hs_s, rd_en_s;
    logic [PTR_W-1:0]  rd_addr_s;
    logic [RW-1:0]     wdata_s, rdata_s;

`ifdef TRACE_FILTER_EN
    assign pass_s = (pc >= filt_lo) && (pc <= filt_hi);
`else
    logic unused_filt_s;
    assign pass_s        = 1'b1;
    assign unused_filt_s = ^{filt_lo, filt_hi};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Control strobes decoded from the current state and inputs.
    always_comb begin
        active_s    = (state_r == ARMED) || (state_r == POST);
        clear_s     = arm && (state_r != READ);
        cap_s       = active_s && m1_strobe && pass_s && !arm;
        step_inc_s  = active_s && m1_strobe && !arm;
        // A record captured this cycle is evaluated against the trigger.
        trig_s      = (state_r == ARMED) && !arm &&
                      (force_trig || (cap_s && trig_en && pc_match(pc, trig_pc, trig_mask)));
        post_done_s = (state_r == POST) && cap_s && (post_left_r == POST_W'(1));
        rd_start_s  = (state_r == READ) && !out_valid_r;
        hs_s        = out_valid_r && out_if.out_ready;
        last_hs_s   = hs_s && (remaining_r == CNT_W'(1));
        rd_en_s     = (rd_start_s && (count_r != CNT_W'(0))) || (hs_s && !last_hs_s);
        if (rd_start_s) begin
            rd_addr_s = wr_ptr_r - count_r[PTR_W-1:0];
        end else begin
            rd_addr_s = rd_ptr_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clear_s) next_state_s = ARMED;
                else         next_state_s = IDLE;
            end
            ARMED: begin
                if (clear_s)                             next_state_s = ARMED;
                else if (trig_s && (post_count == '0))   next_state_s = READ;
                else if (trig_s)                         next_state_s = POST;
                else                                     next_state_s = ARMED;
            end
            POST: begin
                if (clear_s)          next_state_s = ARMED;
                else if (post_done_s) next_state_s = READ;
                else                  next_state_s = POST;
            end
            READ: begin
                if (rd_start_s && (count_r == CNT_W'(0))) next_state_s = IDLE;
                else if (last_hs_s)                       next_state_s = IDLE;
                else                                      next_state_s = READ;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Record word assembled from the tapped CPU state.
    always_comb begin
        wdata_s                        = '0;
        wdata_s[HL_LSB +: 16]          = hl;
        wdata_s[F_LSB +: 8]            = f;
        wdata_s[A_LSB +: 8]            = a;
        wdata_s[PC_LSB +: 16]          = pc;
        wdata_s[STEP_LSB +: STEP_W]    = step_r;
    end

    // Capture pointers, step counter and trigger bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            count_r     <= '0;
            step_r      <= '0;
            post_left_r <= '0;
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (clear_s) begin
            wr_ptr_r    <= '0;
            count_r     <= '0;
            step_r      <= '0;
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (cap_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (count_r == CNT_W'(DEPTH)) overflow_r <= 1'b1;
                else                          count_r    <= count_r + CNT_W'(1);
            end
            if (step_inc_s) begin
                step_r <= step_r + STEP_W'(1);
            end
            if (trig_s) begin
                triggered_r <= 1'b1;
                post_left_r <= post_count;
            end else if ((state_r == POST) && cap_s) begin
                post_left_r <= post_left_r - POST_W'(1);
            end
        end
    end

    // Replay engine: loads the oldest record, then advances on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r    <= '0;
            remaining_r <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            if (rd_start_s) begin
                rd_ptr_r    <= rd_addr_s + PTR_W'(1);
                remaining_r <= count_r;
                out_valid_r <= (count_r != CNT_W'(0));
                out_last_r  <= (count_r == CNT_W'(1));
            end else if (last_hs_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else if (hs_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
                remaining_r <= remaining_r - CNT_W'(1);
                out_last_r  <= (remaining_r == CNT_W'(2));
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cap_s),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .re    (rd_en_s),
        .raddr (rd_addr_s),
        .rdata (rdata_s)
    );

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_last  = out_last_r;
    assign out_if.out_data  = rdata_s;
    assign busy             = busy_r;
    assign triggered        = triggered_r;
    assign overflow         = overflow_r;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with a scoreboard of expected replay records.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m1_strobe, arm, force_trig, trig_en;
    logic [15:0] pc, hl, trig_pc, trig_mask, filt_lo, filt_hi;
    logic [7:0]  a, f, post_count;
    logic        busy, triggered, overflow;

    cpu_trace_buffer_if #(.STEP_W(16)) sif ();

    cpu_trace_buffer #(.DEPTH(16), .STEP_W(16), .POST_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m1_strobe  (m1_strobe),
        .pc         (pc),
        .a          (a),
        .f          (f),
        .hl         (hl),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .filt_lo    (filt_lo),
        .filt_hi    (filt_hi),
        .out_if     (sif),
        .busy       (busy),
        .triggered  (triggered),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          mst     = 0;
    int          m_post  = 0;
    logic [15:0] m_step  = 16'd0;
    logic        m_ovf   = 1'b0;
    logic        m_trig  = 1'b0;
    logic [63:0] sb_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input logic [15:0] p);
`ifdef TRACE_FILTER_EN
        return (p >= filt_lo) && (p <= filt_hi);
`else
        return 1'b1;
`endif
    endfunction

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        mst = 1; m_step = 16'd0; m_ovf = 1'b0; m_trig = 1'b0;
        sb_q.delete();
        chk1("busy_armed", busy, 1'b1);
    endtask

    task automatic fetch(input logic [15:0] p, input logic ft);
        logic cap;
        a = 8'($urandom); f = 8'($urandom); hl = 16'($urandom);
        pc = p; m1_strobe = 1'b1; force_trig = ft;
        if (mst == 1 || mst == 2) begin
            cap = in_win(p);
            if (cap) begin
                if (sb_q.size() == 16) begin
                    void'(sb_q.pop_front());
                    m_ovf = 1'b1;
                end
                sb_q.push_back({m_step, p, a, f, hl});
            end
            m_step = m_step + 16'd1;
            if (mst == 1 && (ft || (cap && trig_en && (((p ^ trig_pc) & trig_mask) == 16'h0000)))) begin
                m_trig = 1'b1;
                if (post_count == 8'd0) mst = 3;
                else begin mst = 2; m_post = int'(post_count); end
            end else if (mst == 2 && cap) begin
                m_post--;
                if (m_post == 0) mst = 3;
            end
        end
        tick();
        m1_strobe = 1'b0; force_trig = 1'b0;
        tick();
    endtask

    task automatic drain(input int stall_at);
        int n = 0;
        int budget = 300;
        logic [63:0] exp;
        chk1("triggered", triggered, m_trig);
        chk1("overflow", overflow, m_ovf);
        sif.out_ready = 1'b1;
        while (sb_q.size() > 0 && budget > 0) begin
            if (sif.out_valid) begin
                if (n == stall_at) begin
                    sif.out_ready = 1'b0;
                    repeat (10) begin
                        tick();
                        chk1("stall_valid", sif.out_valid, 1'b1);
                        chk64("stall_data", sif.out_data, sb_q[0]);
                    end
                    sif.out_ready = 1'b1;
                end
                exp = sb_q.pop_front();
                chk64("beat_data", sif.out_data, exp);
                chk1("beat_last", sif.out_last, sb_q.size() == 0);
                n++;
            end
            tick();
            budget--;
        end
        chk1("drain_in_budget", budget > 0, 1'b1);
        chk1("valid_after_last", sif.out_valid, 1'b0);
        chk1("busy_after_last", busy, 1'b0);
        sif.out_ready = 1'b0;
        mst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; m1_strobe = 1'b0; arm = 1'b0; force_trig = 1'b0; trig_en = 1'b0;
        pc = 16'h0; hl = 16'h0; a = 8'h0; f = 8'h0; trig_pc = 16'h0; trig_mask = 16'h0;
        filt_lo = 16'h0000; filt_hi = 16'hFFFF; post_count = 8'd0; sif.out_ready = 1'b0;
        repeat (3) tick();
        chk1("rst_valid", sif.out_valid, 1'b0);
        chk1("rst_last", sif.out_last, 1'b0);
        chk64("rst_data", sif.out_data, 64'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_trig", triggered, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Five fetches, forced trigger on the fifth, no post window.
        do_arm();
        for (int i = 0; i < 5; i++) fetch(16'(i), i == 4);
        drain(-1);

        // Forty fetches overrun the sixteen-entry window; exact PC trigger.
        trig_en = 1'b1; trig_pc = 16'h1027; trig_mask = 16'hFFFF;
        do_arm();
        for (int i = 0; i < 40; i++) fetch(16'h1000 + 16'(i), 1'b0);
        drain(5);

        // Masked trigger at 0x0100 followed by three post-trigger records.
        trig_pc = 16'h0100; trig_mask = 16'hFF00; post_count = 8'd3;
        do_arm();
        for (int i = 0; i <= 32; i++) fetch(16'h00F0 + 16'(i), 1'b0);
        drain(2);

        // Reset while in POST clears everything immediately.
        trig_en = 1'b0; post_count = 8'd5;
        do_arm();
        fetch(16'h3000, 1'b1);
        fetch(16'h3001, 1'b0);
        chk1("post_busy", busy, 1'b1);
        chk1("post_trig", triggered, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_trig", triggered, 1'b0);
        chk1("midrst_ovf", overflow, 1'b0);
        chk1("midrst_valid", sif.out_valid, 1'b0);
        chk1("midrst_last", sif.out_last, 1'b0);
        chk64("midrst_data", sif.out_data, 64'h0);
        tick();
        rst_n = 1'b1;
        mst = 0;
        tick();

        // Re-arm while ARMED restarts step; a fetch coinciding with arm is dropped.
        post_count = 8'd0;
        do_arm();
        for (int i = 0; i < 3; i++) fetch(16'h2100 + 16'(i), 1'b0);
        arm = 1'b1; m1_strobe = 1'b1; pc = 16'hAAAA;
        tick();
        arm = 1'b0; m1_strobe = 1'b0;
        mst = 1; m_step = 16'd0; m_ovf = 1'b0; m_trig = 1'b0; sb_q.delete();
        tick();
        for (int i = 0; i < 3; i++) fetch(16'h2000 + 16'(i), i == 2);
        drain(0);

        // Window filter: only in-range PCs are kept (ignored in the default build).
        filt_lo = 16'h0200; filt_hi = 16'h02FF;
`ifndef TRACE_FILTER_EN
        filt_lo = 16'h0300; filt_hi = 16'h0100;
`endif
        do_arm();
        fetch(16'h01FF, 1'b0);
        fetch(16'h0200, 1'b0);
        fetch(16'h0300, 1'b0);
        fetch(16'h0250, 1'b0);
        fetch(16'h02FF, 1'b0);
        fetch(16'h0100, 1'b0);
        fetch(16'h0280, 1'b1);
        drain(-1);

`ifdef TRACE_FILTER_EN
        // Nothing captured: replay produces no beats and returns to idle.
        do_arm();
        fetch(16'h0000, 1'b1);
        chk1("empty_valid", sif.out_valid, 1'b0);
        drain(-1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
